multicycle_ctrl: RTL and testbench

//  Multicycle control unit: an FSM sequences the shared ALU, memory port and register file across

---
 rtl/alu_pkg.sv | 105 ++++++++++
 rtl/cond_unit.sv | 36 +++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multicycle control unit: ALU opcodes, FSM states, ARM condition codes
// and the condition-check function used to gate architectural writes.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'b0000,
    AluSub = 4'b0001,
    AluAnd = 4'b0010,
    AluOrr = 4'b0011
  } alu_op_e;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } ctrl_state_e;

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  // Instruction class in instr[27:26].
  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;

  // Data-processing cmd field in funct[4:1].
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluDirect = 2'b10;

  localparam logic [1:0] ImmDp     = 2'b00;
  localparam logic [1:0] ImmMem    = 2'b01;
  localparam logic [1:0] ImmBranch = 2'b10;

  // Flags are packed NZCV: [3]=N, [2]=Z, [1]=C, [0]=V.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, res;
    {n, z, c, v} = flags;
    case (cond)
      CondEq:  res = z;
      CondNe:  res = ~z;
      CondCs:  res = c;
      CondCc:  res = ~c;
      CondMi:  res = n;
      CondPl:  res = ~n;
      CondVs:  res = v;
      CondVc:  res = ~v;
      CondHi:  res = c & ~z;
      CondLs:  res = ~c | z;
      CondGe:  res = (n == v);
      CondLt:  res = (n != v);
      CondGt:  res = ~z & (n == v);
      CondLe:  res = z | (n != v);
      CondAl:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic alu_op_e cmd_to_alu(input logic [3:0] cmd);
    alu_op_e res;
    case (cmd)
      CmdAdd:         res = AluAdd;
      CmdSub, CmdCmp: res = AluSub;
      CmdAnd:         res = AluAnd;
      CmdOrr:         res = AluOrr;
      default:        res = AluAdd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register plus conditional-execution check. A flag update is only taken when the
// instruction's own condition passes, evaluated against the pre-instruction flags.
module cond_unit
  import alu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flags_upd,
  output logic       cond_ex,
  output logic [3:0] flags_q
);

  logic [3:0] flags_d;

  assign cond_ex = cond_check(cond, flags_q);

  always_comb begin
    flags_d = flags_q;
    if (flags_upd && cond_ex) begin
      flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback over a shared ALU,
// memory port and register file, driving datapath mux selects and write enables.
module multicycle_ctrl
  import alu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ready,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_w,
  output logic       ir_w,
  output logic       mem_w,
  output logic       reg_w,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] alu_control,
  output logic [3:0] flags_q
);

  ctrl_state_e state_q, state_d;
  logic        cond_ex;
  logic        is_cmp;
  logic        flags_upd;
  alu_op_e     dp_op;
  logic        pc_w_raw, ir_w_raw, mem_w_raw, reg_w_raw;

  assign is_cmp    = (funct[4:1] == CmdCmp);
  assign dp_op     = cmd_to_alu(funct[4:1]);
  assign flags_upd = (state_q == StAluWb) && (funct[0] || is_cmp);

  cond_unit #(
    .FLAGS_RST(FLAGS_RST)
  ) u_cond_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .cond     (cond),
    .alu_flags(alu_flags),
    .flags_upd(flags_upd),
    .cond_ex  (cond_ex),
    .flags_q  (flags_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpMem:    state_d = StMemAdr;
          OpDp:     state_d = funct[5] ? StExecI : StExecR;
          OpBranch: state_d = StBranch;
          default:  state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
      end
      StExecR, StExecI: state_d = StAluWb;
      StAluWb, StBranch: state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_w_raw    = 1'b0;
    ir_w_raw    = 1'b0;
    mem_w_raw   = 1'b0;
    reg_w_raw   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SrcBReg;
    result_src  = ResAluOut;
    alu_control = AluAdd;
    case (state_q)
      StFetch: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluDirect;
        ir_w_raw   = mem_ready;
        pc_w_raw   = mem_ready;
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluDirect;
      end
      StMemAdr: begin
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = ResReadData;
        reg_w_raw  = cond_ex;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_w_raw = cond_ex;
      end
      StExecR: begin
        alu_src_b   = SrcBReg;
        alu_control = dp_op;
      end
      StExecI: begin
        alu_src_b   = SrcBImm;
        alu_control = dp_op;
      end
      StAluWb: begin
        result_src  = ResAluOut;
        alu_control = dp_op;
        reg_w_raw   = cond_ex & ~is_cmp;
        // A write to R15 redirects the PC through the same result bus.
        pc_w_raw    = cond_ex & ~is_cmp & (rd == 4'd15);
      end
      StBranch: begin
        alu_src_b  = SrcBImm;
        result_src = ResAluDirect;
        pc_w_raw   = cond_ex;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OpMem:    imm_src = ImmMem;
      OpBranch: imm_src = ImmBranch;
      default:  imm_src = ImmDp;
    endcase
    reg_src = {(op == OpMem) & ~funct[0], op == OpBranch};
  end

  // State resets to FETCH asynchronously, so the fetch strobes must be masked during reset.
  assign pc_w  = pc_w_raw & rst_n;
  assign ir_w  = ir_w_raw & rst_n;
  assign mem_w = mem_w_raw & rst_n;
  assign reg_w = reg_w_raw & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction phase model with a per-cycle compare
// process, plus literal checks on latency, ALU op selection and flag values.
module tb_multicycle_ctrl;
  import alu_pkg::*;

  localparam int PhF = 0, PhD = 1, PhMa = 2, PhMr = 3, PhMwb = 4, PhMw = 5;
  localparam int PhEr = 6, PhEi = 7, PhAw = 8, PhB = 9, PhIdle = 10;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready;
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       pc_w, ir_w, mem_w, reg_w, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src;
  logic [3:0] alu_control, flags_q;

  multicycle_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ready  (mem_ready),
    .cond       (cond),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .alu_flags  (alu_flags),
    .pc_w       (pc_w),
    .ir_w       (ir_w),
    .mem_w      (mem_w),
    .reg_w      (reg_w),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .reg_src    (reg_src),
    .alu_control(alu_control),
    .flags_q    (flags_q)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  model_flags = 4'b0000;
  bit          exp_valid = 1'b0;
  int          cur_phase = PhIdle;
  logic        exp_pc_w, exp_ir_w, exp_mem_w, exp_reg_w;
  logic [13:0] exp_mux, exp_mask, act_mux;
  logic [3:0]  exec_alu;
  int          instr_cycles = 0;

  assign act_mux = {imm_src, reg_src, adr_src, alu_src_a, alu_src_b, result_src, alu_control};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ARM conditions come in complementary pairs: cond[3:1] picks the test, cond[0] inverts it.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] & ~f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic logic [3:0] cmd_op(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return AluSub;
      4'b0000:          return AluAnd;
      4'b1100:          return AluOrr;
      default:          return AluAdd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("pc_w", 16'(pc_w), 16'(exp_pc_w));
      chk("ir_w", 16'(ir_w), 16'(exp_ir_w));
      chk("mem_w", 16'(mem_w), 16'(exp_mem_w));
      chk("reg_w", 16'(reg_w), 16'(exp_reg_w));
      chk("flags_q", 16'(flags_q), 16'(model_flags));
      chk("mux_fields", 16'(act_mux & exp_mask), 16'(exp_mux & exp_mask));
      if (ir_w) instr_cycles = 1;
      else instr_cycles++;
      if (cur_phase == PhEr || cur_phase == PhEi) exec_alu = alu_control;
    end
  end

  // One cycle of a given phase: set expectations, advance to just after the next rising edge.
  task automatic do_phase(input int p, input logic mr);
    logic pass, cmp, adr, sa;
    logic [1:0] sb, rs, imm, rsrc;
    logic [3:0] ac;
    logic [4:0] m;  // care bits: adr, src_a, src_b, result_src, alu_control
    pass = cond_pass(cond, model_flags);
    cmp  = (funct[4:1] == 4'b1010);
    mem_ready = mr;
    cur_phase = p;
    exp_pc_w = 1'b0; exp_ir_w = 1'b0; exp_mem_w = 1'b0; exp_reg_w = 1'b0;
    adr = 1'b0; sa = 1'b0; sb = 2'b00; rs = 2'b00; ac = AluAdd; m = 5'b00000;
    case (p)
      PhF:   begin sa = 1; sb = 2'b10; rs = 2'b10; m = 5'b11111; exp_pc_w = mr; exp_ir_w = mr; end
      PhD:   begin sa = 1; sb = 2'b10; rs = 2'b10; m = 5'b01111; end
      PhMa:  begin sb = 2'b01; m = 5'b01101; end
      PhMr:  begin adr = 1; m = 5'b10000; end
      PhMwb: begin rs = 2'b01; m = 5'b00010; exp_reg_w = pass; end
      PhMw:  begin adr = 1; m = 5'b10000; exp_mem_w = pass; end
      PhEr:  begin sb = 2'b00; ac = cmd_op(funct[4:1]); m = 5'b00101; end
      PhEi:  begin sb = 2'b01; ac = cmd_op(funct[4:1]); m = 5'b00101; end
      PhAw:  begin
        m = 5'b00010;
        exp_reg_w = pass && !cmp;
        exp_pc_w = exp_reg_w && (rd == 4'd15);
      end
      PhB:   begin sb = 2'b01; rs = 2'b10; m = 5'b01111; exp_pc_w = pass; end
      default: ;
    endcase
    imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    rsrc = {op == 2'b01 && !funct[0], op == 2'b10};
    exp_mux  = {imm, rsrc, adr, sa, sb, rs, ac};
    exp_mask = {(op == 2'b11) ? 2'b00 : 2'b11, 2'b11, m[4], m[3], {2{m[2]}}, {2{m[1]}},
                {4{m[0]}}};
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    if (p == PhAw && pass && (funct[0] || cmp)) model_flags = alu_flags;
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af, input int fw, input int mw);
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    for (int i = 0; i < fw; i++) do_phase(PhF, 1'b0);
    do_phase(PhF, 1'b1);
    do_phase(PhD, 1'b1);
    case (o)
      2'b01: begin
        do_phase(PhMa, 1'b1);
        if (f[0]) begin
          for (int i = 0; i < mw; i++) do_phase(PhMr, 1'b0);
          do_phase(PhMr, 1'b1);
          do_phase(PhMwb, 1'b1);
        end else begin
          for (int i = 0; i < mw; i++) do_phase(PhMw, 1'b0);
          do_phase(PhMw, 1'b1);
        end
      end
      2'b00: begin
        do_phase(f[5] ? PhEi : PhEr, 1'b1);
        do_phase(PhAw, 1'b1);
      end
      2'b10: do_phase(PhB, 1'b1);
      default: ;
    endcase
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; mem_ready = 1'b1;
    cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pc_w", 16'(pc_w), 16'(0));
    chk("rst_ir_w", 16'(ir_w), 16'(0));
    chk("rst_mem_w", 16'(mem_w), 16'(0));
    chk("rst_reg_w", 16'(reg_w), 16'(0));
    chk("rst_flags", 16'(flags_q), 16'(4'b0000));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b1111, 0, 0);   // ADD R1,R2,R3
    chk("lat_add", 16'(instr_cycles), 16'(4));
    chk("add_alu", 16'(exec_alu), 16'(AluAdd));
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0, 0);   // SUBS
    chk("subs_flags", 16'(flags_q), 16'(4'b0100));
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0);   // BEQ taken
    chk("lat_b", 16'(instr_cycles), 16'(3));
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, 0, 0);   // SUBS, Z=0
    chk("subs_flags_z0", 16'(flags_q), 16'(4'b0000));
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0);   // BEQ not taken
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 2, 3);   // LDR, stalled fetch and read
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 0, 0);   // LDR
    chk("lat_ldr", 16'(instr_cycles), 16'(5));
    run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000, 0, 0);   // STR
    chk("lat_str", 16'(instr_cycles), 16'(4));
    run_instr(4'hF, 2'b01, 6'b011000, 4'd3, 4'b0000, 0, 1);   // STR cond=1111
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1000, 0, 0);   // CMP
    chk("cmp_alu", 16'(exec_alu), 16'(AluSub));
    chk("cmp_flags", 16'(flags_q), 16'(4'b1000));
    run_instr(4'hE, 2'b00, 6'b111000, 4'd4, 4'b0000, 0, 0);   // ORR imm
    chk("orr_alu", 16'(exec_alu), 16'(AluOrr));
    run_instr(4'hE, 2'b00, 6'b000000, 4'd4, 4'b0000, 0, 0);   // AND
    run_instr(4'hE, 2'b00, 6'b011010, 4'd4, 4'b0000, 0, 0);   // unmapped cmd -> ADD
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 0, 0);   // undefined
    chk("lat_undef", 16'(instr_cycles), 16'(2));
    run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, 0, 0);  // ADD PC,...
    run_instr(4'h5, 2'b00, 6'b001001, 4'd5, 4'b0010, 0, 0);   // ADDSPL, fails with N=1
    chk("pl_flags_kept", 16'(flags_q), 16'(4'b1000));
    run_instr(4'h4, 2'b00, 6'b001000, 4'd5, 4'b0000, 0, 0);   // ADDMI, passes

    // Reset while a store is stalled with mem_w asserted.
    cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd3; alu_flags = 4'd0;
    do_phase(PhF, 1'b1);
    do_phase(PhD, 1'b1);
    do_phase(PhMa, 1'b1);
    do_phase(PhMw, 1'b0);
    do_phase(PhMw, 1'b0);
    exp_valid = 1'b0;
    cur_phase = PhIdle;
    chk("memwr_mem_w", 16'(mem_w), 16'(1));
    #1 rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("midrst_mem_w", 16'(mem_w), 16'(0));
    chk("midrst_pc_w", 16'(pc_w), 16'(0));
    chk("midrst_ir_w", 16'(ir_w), 16'(0));
    chk("midrst_reg_w", 16'(reg_w), 16'(0));
    @(negedge clk);
    chk("midrst_flags", 16'(flags_q), 16'(4'b0000));
    chk("midrst_ir_w_hold", 16'(ir_w), 16'(0));
    mem_ready = 1'b0;
    rst_n = 1'b1;
    model_flags = 4'b0000;
    @(posedge clk);
    #1;
    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000, 0, 0);   // ADD after reset
    chk("lat_add_post_rst", 16'(instr_cycles), 16'(4));

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
